// File: rtl/ahb_lite_master.sv
// Purpose: single-outstanding AHB-Lite initiator; turns valid/ready commands into SINGLE read/write transfers.
// Latency: accept edge to response edge is 3 edges with zero wait states, plus 1 per wait state, plus 1 for an ERROR response.
// Backpressure: cmd_ready is high only in IDLE; responses are one-cycle pulses with no backpressure.
//
// Ports:
//   hclk, hresetn                 clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_write, cmd_addr, cmd_wdata, cmd_size are the fields
//   rsp_valid                     completion pulse; rsp_rdata, rsp_error, rsp_timeout qualify it
//   hsel, haddr, htrans, hwrite,  AHB-Lite address phase (registered)
//   hsize, hburst, hprot
//   hwdata                        AHB-Lite write data (registered, held until next write data phase)
//   hrdata, hready, hresp         AHB-Lite slave response
module ahb_lite_master #(
    parameter int addr_width     = 14,
    parameter int bus_width      = 32,
    parameter int timeout_cycles = 256
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [bus_width-1:0]  cmd_wdata,
    input  logic [2:0]            cmd_size,
    output logic                  rsp_valid,
    output logic [bus_width-1:0]  rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  hsel,
    output logic [addr_width-1:0] haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [3:0]            hprot,
    output logic [bus_width-1:0]  hwdata,
    input  logic [bus_width-1:0]  hrdata,
    input  logic                  hready,
    input  logic [1:0]            hresp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [1:0] trans_idle   = 2'b00;
    localparam logic [1:0] trans_nonseq = 2'b10;
    localparam logic [1:0] resp_okay    = 2'b00;

    localparam int                   cnt_width = $clog2(timeout_cycles + 2);
    localparam logic [cnt_width-1:0] cnt_limit = cnt_width'(timeout_cycles);
    localparam logic [cnt_width-1:0] cnt_one   = cnt_width'(1);

    state_t                  state, state_nxt;
    logic [cnt_width-1:0]    cnt, cnt_nxt, cnt_inc;
    logic [bus_width-1:0]    wdata_q, wdata_nxt;

    logic                    hsel_nxt, hwrite_nxt;
    logic [addr_width-1:0]   haddr_nxt;
    logic [1:0]              htrans_nxt;
    logic [2:0]              hsize_nxt;
    logic [bus_width-1:0]    hwdata_nxt;
    logic                    rsp_valid_nxt, rsp_error_nxt, rsp_timeout_nxt;
    logic [bus_width-1:0]    rsp_rdata_nxt;

    logic                    illegal;
    logic                    expired;

    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign cmd_ready = (state == IDLE);

    // Oversized or misaligned commands never reach the bus.
    assign illegal = (cmd_size > 3'd2)
                  || ((cmd_size == 3'd1) && cmd_addr[0])
                  || ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));

    // The counter is loaded with 1 at the accept edge so that it counts edges
    // including the accept edge; the abort is registered on the edge that
    // brings that count to timeout_cycles, making the response visible
    // exactly timeout_cycles cycles after accept.
    assign cnt_inc = cnt + cnt_one;
    assign expired = (timeout_cycles != 0) && (cnt_inc >= cnt_limit);

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        wdata_nxt       = wdata_q;
        hsel_nxt        = hsel;
        haddr_nxt       = haddr;
        htrans_nxt      = htrans;
        hwrite_nxt      = hwrite;
        hsize_nxt       = hsize;
        hwdata_nxt      = hwdata;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_error_nxt   = 1'b0;
        rsp_timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cnt_nxt   = cnt_one;
                    wdata_nxt = cmd_wdata;
                    if (illegal) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_error_nxt = 1'b1;
                        rsp_rdata_nxt = '0;
                    end else begin
                        htrans_nxt = trans_nonseq;
                        hsel_nxt   = 1'b1;
                        haddr_nxt  = cmd_addr;
                        hwrite_nxt = cmd_write;
                        hsize_nxt  = cmd_size;
                        state_nxt  = ADDR;
                    end
                end
            end
            ADDR: begin
                cnt_nxt = cnt_inc;
                if (hready) begin
                    htrans_nxt = trans_idle;
                    hsel_nxt   = 1'b0;
                    if (hwrite) begin
                        hwdata_nxt = wdata_q;
                    end
                    state_nxt = DATA;
                end
            end
            DATA: begin
                cnt_nxt = cnt_inc;
                if (hready) begin
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = IDLE;
                    if (hresp == resp_okay) begin
                        rsp_rdata_nxt = hwrite ? '0 : hrdata;
                    end else begin
                        rsp_error_nxt = 1'b1;
                        rsp_rdata_nxt = '0;
                    end
                end else if (hresp != resp_okay) begin
                    state_nxt = ERR;
                end
            end
            ERR: begin
                cnt_nxt = cnt_inc;
                if (hready) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_error_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides everything except a completion on the same edge.
        if ((state != IDLE) && expired && !rsp_valid_nxt) begin
            htrans_nxt      = trans_idle;
            hsel_nxt        = 1'b0;
            hwdata_nxt      = hwdata;
            rsp_valid_nxt   = 1'b1;
            rsp_timeout_nxt = 1'b1;
            rsp_error_nxt   = 1'b0;
            rsp_rdata_nxt   = '0;
            state_nxt       = IDLE;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state       <= IDLE;
            cnt         <= '0;
            wdata_q     <= '0;
            hsel        <= 1'b0;
            haddr       <= '0;
            htrans      <= trans_idle;
            hwrite      <= 1'b0;
            hsize       <= 3'd0;
            hwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            wdata_q     <= wdata_nxt;
            hsel        <= hsel_nxt;
            haddr       <= haddr_nxt;
            htrans      <= htrans_nxt;
            hwrite      <= hwrite_nxt;
            hsize       <= hsize_nxt;
            hwdata      <= hwdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_error   <= rsp_error_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Purpose: self-checking bench for ahb_lite_master with a scripted AHB slave and a response scoreboard.
// Latency: expected response edge is derived per command from its wait-state script.
// Backpressure: commands are issued one at a time; each waits for its response before the next.
module tb_ahb_lite_master;

    localparam int aw = 14;
    localparam int bw = 32;
    localparam int to = 8;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [aw-1:0] cmd_addr = '0;
    logic [bw-1:0] cmd_wdata = '0;
    logic [2:0]    cmd_size = 3'd0;
    logic          rsp_valid;
    logic [bw-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          hsel;
    logic [aw-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [bw-1:0] hwdata;
    logic [bw-1:0] hrdata = '0;
    logic          hready = 1'b1;
    logic [1:0]    hresp = 2'b00;

    ahb_lite_master #(
        .addr_width     (aw),
        .bus_width      (bw),
        .timeout_cycles (to)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_size    (cmd_size),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .hsel        (hsel),
        .haddr       (haddr),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hburst      (hburst),
        .hprot       (hprot),
        .hwdata      (hwdata),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp)
    );

    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    typedef struct {
        logic [bw-1:0] rdata;
        logic          err;
        logic          tmo;
        int            rsp_edge;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest expectation.
    always @(negedge hclk) begin
        exp_t e;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_error",   {63'd0, rsp_error},   {63'd0, e.err});
                check("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, e.tmo});
                check("rsp_rdata",   {32'd0, rsp_rdata},   {32'd0, e.rdata});
                check("rsp_edge",    64'(cyc),             64'(e.rsp_edge));
            end
        end
    end

    // Issue one command and play the slave side for it.
    //   aws/dws: wait states in address/data phase; err: two-cycle ERROR; hang: hready stuck low.
    task automatic run_cmd(input string tag, input logic wr, input logic [aw-1:0] a,
                           input logic [bw-1:0] wd, input logic [2:0] sz, input int aws,
                           input int dws, input bit err, input bit hang, input logic [bw-1:0] rd);
        exp_t e;
        bit   rej;
        int   lat;
        rej = (sz > 3'd2) || ((sz == 3'd1) && a[0]) || ((sz == 3'd2) && (a[1:0] != 2'b00));
        e.rdata = '0;
        e.err   = 1'b0;
        e.tmo   = 1'b0;
        if (rej) begin
            e.err = 1'b1;
            lat   = 1;
        end else if (hang) begin
            e.tmo = 1'b1;
            lat   = to;
        end else if (err) begin
            e.err = 1'b1;
            lat   = 3 + aws + 1;
        end else begin
            lat = 3 + aws + dws;
            if (!wr) e.rdata = rd;
        end

        @(negedge hclk);
        check({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_size  = sz;
        @(posedge hclk);
        #1;
        cmd_valid  = 1'b0;
        e.rsp_edge = cyc + lat - 1;
        sb.push_back(e);

        if (rej) begin
            @(negedge hclk);
            check({tag, "_no_nonseq"}, {62'd0, htrans}, 64'd0);
        end else if (hang) begin
            hready = 1'b0;
            for (int i = 1; i < lat; i++) begin
                @(negedge hclk);
                check({tag, "_htrans_hold"}, {62'd0, htrans}, 64'd2);
                @(posedge hclk);
                #1;
            end
            @(negedge hclk);
            check({tag, "_htrans_abort"}, {62'd0, htrans}, 64'd0);
            check({tag, "_hsel_abort"},   {63'd0, hsel},   64'd0);
            hready = 1'b1;
        end else begin
            for (int i = 0; i <= aws; i++) begin
                hready = (i == aws);
                @(negedge hclk);
                check({tag, "_htrans_addr"}, {62'd0, htrans}, 64'd2);
                if (i == aws) begin
                    check({tag, "_hsel"},   {63'd0, hsel},   64'd1);
                    check({tag, "_haddr"},  {50'd0, haddr},  {50'd0, a});
                    check({tag, "_hwrite"}, {63'd0, hwrite}, {63'd0, wr});
                    check({tag, "_hsize"},  {61'd0, hsize},  {61'd0, sz});
                end
                @(posedge hclk);
                #1;
            end
            if (err) begin
                hready = 1'b0;
                hresp  = 2'b01;
                @(negedge hclk);
                check({tag, "_htrans_err1"}, {62'd0, htrans}, 64'd0);
                @(posedge hclk);
                #1;
                hready = 1'b1;
                @(negedge hclk);
                check({tag, "_htrans_err2"}, {62'd0, htrans}, 64'd0);
                @(posedge hclk);
                #1;
            end else begin
                for (int i = 0; i <= dws; i++) begin
                    hready = (i == dws);
                    hrdata = (i == dws) ? rd : 32'hBAD0_BAD0;
                    @(negedge hclk);
                    if (i == dws) check({tag, "_htrans_data"}, {62'd0, htrans}, 64'd0);
                    if (wr) check({tag, "_hwdata"}, {32'd0, hwdata}, {32'd0, wd});
                    @(posedge hclk);
                    #1;
                end
            end
            hready = 1'b1;
            hresp  = 2'b00;
            hrdata = '0;
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge hclk);
        if (sb.size() != 0) begin
            check({tag, "_rsp_pending"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

    initial begin
        // Reset held with a command pending: nothing may move.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 14'h10;
        cmd_size  = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            check("rst_htrans",    {62'd0, htrans},    64'd0);
            check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            check("rst_hsel",      {63'd0, hsel},      64'd0);
        end
        cmd_valid = 1'b0;
        hresetn   = 1'b1;
        @(negedge hclk);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_hwdata",    {32'd0, hwdata},    64'd0);
        check("hburst",        {61'd0, hburst},    64'd0);
        check("hprot",         {60'd0, hprot},     64'd3);

        //       tag         wr    addr    wdata         sz  aws dws err hang rdata
        run_cmd("wr_zw",    1'b1, 14'h10, 32'hDEADBEEF, 3'd2, 0, 0, 1'b0, 1'b0, 32'h0);
        run_cmd("rd_dw2",   1'b0, 14'h24, 32'h0,        3'd2, 0, 2, 1'b0, 1'b0, 32'h12345678);
        run_cmd("rd_err",   1'b0, 14'h30, 32'h0,        3'd2, 0, 0, 1'b1, 1'b0, 32'h0);
        run_cmd("rej_mis",  1'b1, 14'h02, 32'h11111111, 3'd2, 0, 0, 1'b0, 1'b0, 32'h0);
        run_cmd("rej_sz3",  1'b0, 14'h08, 32'h0,        3'd3, 0, 0, 1'b0, 1'b0, 32'h0);
        run_cmd("wr_byte",  1'b1, 14'h13, 32'hA5000000, 3'd0, 1, 0, 1'b0, 1'b0, 32'h0);
        run_cmd("rd_half",  1'b0, 14'h06, 32'h0,        3'd1, 0, 1, 1'b0, 1'b0, 32'hCAFE0000);
        run_cmd("rej_half", 1'b0, 14'h05, 32'h0,        3'd1, 0, 0, 1'b0, 1'b0, 32'h0);
        run_cmd("tmo",      1'b0, 14'h44, 32'h0,        3'd2, 0, 0, 1'b0, 1'b1, 32'h0);
        run_cmd("wr_post",  1'b1, 14'h48, 32'h0BADF00D, 3'd2, 0, 1, 1'b0, 1'b0, 32'h0);

        // Reset during the data phase of a read: outputs clear at once, no response.
        @(negedge hclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 14'h40;
        cmd_size  = 3'd2;
        @(posedge hclk);
        #1;
        cmd_valid = 1'b0;
        hready    = 1'b1;
        @(posedge hclk);
        #1;
        hready  = 1'b0;
        #2;
        hresetn = 1'b0;
        #1;
        check("mid_rst_htrans",    {62'd0, htrans},    64'd0);
        check("mid_rst_hsel",      {63'd0, hsel},      64'd0);
        check("mid_rst_haddr",     {50'd0, haddr},     64'd0);
        check("mid_rst_hwdata",    {32'd0, hwdata},    64'd0);
        check("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        cmd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge hclk);
            check("mid_rst_hold_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        cmd_valid = 1'b0;
        hready    = 1'b1;
        hresetn   = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge hclk);
        check("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        run_cmd("rd_after", 1'b0, 14'h50, 32'h0, 3'd2, 0, 0, 1'b0, 1'b0, 32'h5A5A5A5A);

        repeat (3) @(posedge hclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
